// File: rtl/binarni_dekadski_if.sv
// binarni_dekadski_if: start/done handshake and BCD result bus for binarni_dekadski.
// master drives the request; slave is the converter.
interface binarni_dekadski_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow,
    input  blank
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow,
    output blank
  );
endinterface

// File: rtl/binarni_dekadski.sv
// binarni_dekadski: sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional leading-zero blanking mask enabled by defining BINARNI_DEKADSKI_BLANK_EN;
// without it the blank port is tied to zero.
module binarni_dekadski #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  binarni_dekadski_if.slave bus
);
  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SW-1:0]    scratch_q, scratch_d;
  logic [SW-1:0]    adj;
  logic             sticky_q, sticky_d;
  logic             last_shift;

  logic             busy_q;
  logic             done_q;
  logic [SW-1:0]    bcd_q;
  logic             ovf_q;

  // Add-3 correction on every scratch digit >= 5, digits independent (no carries)
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    sticky_d   = sticky_q;
    last_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          cnt_d     = CW'(WIDTH);
          shreg_d   = bus.bin;
          scratch_d = '0;
          sticky_d  = 1'b0;
        end
      end
      SHIFT: begin
        scratch_d = {adj[SW-2:0], shreg_q[WIDTH-1]};
        shreg_d   = shreg_q << 1;
        sticky_d  = sticky_q | adj[SW-1];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          last_shift = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Conversion working registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
    end
  end

  // Status flags registered from the next state; result captured on the final shift
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      if (last_shift) begin
        bcd_q <= scratch_d;
        ovf_q <= sticky_d;
      end
    end
  end

`ifdef BINARNI_DEKADSKI_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              zero_above;

  // Leading-zero mask of the final scratch value; the units digit is never blanked
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above & (scratch_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  // Blank mask registered alongside bcd; reset shows a single "0"
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= ~(DIGITS'(1));
    end else if (last_shift) begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
